// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared data width and arbiter FSM encoding, also used by the IO controller.
package dmem_arbiter_pkg;
  localparam int DW = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug-master and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_write, cpu_read, cpu_stall;
  logic          dbg_req, dbg_write, dbg_ack;
  logic [DW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_write, mem_read;
  logic          grant_dbg;
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write, cpu_read,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output grant_dbg
  );
  modport master (
    output cpu_addr, cpu_wdata, cpu_write, cpu_read,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_write, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  grant_dbg
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU (fixed priority) and a debug master
// that is forced through after STARVE_LIMIT consecutive losses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e        r_state, w_state_nx;
  logic [3:0]    r_wait_cnt, w_wait_cnt_nx;
  logic          r_dbg_ack, w_dbg_ack_nx;
  logic [DW-1:0] r_dbg_rdata, w_dbg_rdata_nx;
  logic          w_cpu_req, w_dbg_elig, w_starve, w_grant;
  assign w_cpu_req  = bus.cpu_read | bus.cpu_write;
  // Gating with reset forces the grant (and everything derived from it) low during reset.
  assign w_dbg_elig = i_rst_n & bus.dbg_req & (r_state != ST_ACK);
  assign w_starve   = r_wait_cnt >= LIMIT;
  assign w_grant    = w_dbg_elig & (~w_cpu_req | w_starve);
  always_comb begin
    w_state_nx     = ST_IDLE;
    w_wait_cnt_nx  = '0;
    w_dbg_ack_nx   = 1'b0;
    w_dbg_rdata_nx = r_dbg_rdata;
    if (w_grant) begin
      w_state_nx     = ST_ACK;
      w_dbg_ack_nx   = 1'b1;
      w_dbg_rdata_nx = bus.dbg_write ? r_dbg_rdata : bus.mem_rdata;
    end else if (w_dbg_elig) begin
      w_state_nx    = ST_WAIT;
      w_wait_cnt_nx = sat_inc(r_wait_cnt);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_wait_cnt  <= w_wait_cnt_nx;
      r_dbg_ack   <= w_dbg_ack_nx;
      r_dbg_rdata <= w_dbg_rdata_nx;
    end
  end
  assign bus.mem_addr  = w_grant ? bus.dbg_addr  : bus.cpu_addr;
  assign bus.mem_wdata = w_grant ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.mem_write = i_rst_n & (w_grant ? bus.dbg_write  : bus.cpu_write);
  assign bus.mem_read  = i_rst_n & (w_grant ? ~bus.dbg_write : bus.cpu_read);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = w_cpu_req & w_grant;
  assign bus.grant_dbg = w_grant;
  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.dbg_rdata = r_dbg_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] env_mem [256];
  logic [15:0] m_mem [256];
  logic        m_ack;
  int          m_losses;
  logic [15:0] m_rdata;
  dmem_arbiter_if bus ();
  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = env_mem[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_write) env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a debug request that has lost m_losses slots in a row wins once that reaches LIMIT
  // or the CPU is quiet; the cycle after any debug win is its ack cycle and it cannot win there.
  always @(negedge clk) begin
    logic cpu_req, g, e_wr, e_rd;
    logic [15:0] e_addr, e_wdata;
    if (!rst_n) begin
      m_ack = 1'b0;
      m_losses = 0;
      m_rdata = '0;
    end
    cpu_req = bus.cpu_read | bus.cpu_write;
    g       = rst_n && bus.dbg_req && !m_ack && (!cpu_req || m_losses >= LIMIT);
    e_addr  = g ? bus.dbg_addr  : bus.cpu_addr;
    e_wdata = g ? bus.dbg_wdata : bus.cpu_wdata;
    e_wr    = rst_n && (g ? bus.dbg_write  : bus.cpu_write);
    e_rd    = rst_n && (g ? !bus.dbg_write : bus.cpu_read);
    chk("grant_dbg", 32'(bus.grant_dbg), 32'(g));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(cpu_req && g));
    chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
    chk("mem_read",  32'(bus.mem_read),  32'(e_rd));
    chk("dbg_ack",   32'(bus.dbg_ack),   32'(m_ack));
    chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(m_rdata));
    if (e_wr || e_rd) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    if (e_rd) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_mem[e_addr[7:0]]));
    if (g && !bus.dbg_write) m_rdata = m_mem[e_addr[7:0]];
    if (e_wr) m_mem[e_addr[7:0]] = e_wdata;
    m_losses = (!rst_n || g || !(bus.dbg_req && !m_ack)) ? 0 : (m_losses < 15 ? m_losses + 1 : 15);
    m_ack = g;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_write = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      m_mem[i] = '0;
    end
    env_mem[4] = 16'h00A5;
    m_mem[4] = 16'h00A5;
    m_ack = 0; m_losses = 0; m_rdata = '0;
    idle_all();
    bus.cpu_write = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_write", 32'(bus.mem_write), 0);
      chk("rst_dbg_ack", 32'(bus.dbg_ack), 0);
      chk("rst_dbg_rdata", 32'(bus.dbg_rdata), 0);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_mem_write", 32'(bus.mem_write), 1);
    chk("post_rst_stall", 32'(bus.cpu_stall), 0);
    tick();
    idle_all();
    bus.dbg_req = 1; bus.dbg_write = 0; bus.dbg_addr = 16'h0004;
    @(negedge clk);
    chk("rd_grant_c0", 32'(bus.grant_dbg), 1);
    tick();
    @(negedge clk);
    chk("rd_ack_c1", 32'(bus.dbg_ack), 1);
    chk("rd_data_c1", 32'(bus.dbg_rdata), 32'h00A5);
    chk("rd_grant_c1", 32'(bus.grant_dbg), 0);
    tick();
    idle_all();
    @(negedge clk);
    chk("cpu_write_landed", 32'(env_mem[8'h10]), 32'h1234);
    tick();
    bus.cpu_read = 1; bus.cpu_addr = 16'h0020;
    bus.dbg_req = 1; bus.dbg_write = 1; bus.dbg_addr = 16'h00F0; bus.dbg_wdata = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("cont_stall_c%0d", i), 32'(bus.cpu_stall), 32'(i == 4));
      chk($sformatf("cont_ack_c%0d", i), 32'(bus.dbg_ack), 32'(i == 5));
      if (i == 1) chk("cont_wait_cnt_c1", 32'(dut.r_wait_cnt), 1);
      tick();
    end
    idle_all();
    @(negedge clk);
    chk("display_value", 32'(env_mem[8'hF0]), 32'h0003);
    tick();
    bus.dbg_req = 1; bus.dbg_write = 1; bus.dbg_addr = 16'h0030; bus.dbg_wdata = 16'h0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_grant_c%0d", i), 32'(bus.grant_dbg), 32'(i % 2 == 0));
      chk($sformatf("b2b_ack_c%0d", i), 32'(bus.dbg_ack), 32'(i % 2 == 1));
      tick();
      if (i == 0) begin
        bus.dbg_addr = 16'h0031; bus.dbg_wdata = 16'h0022;
      end
    end
    idle_all();
    @(negedge clk);
    chk("b2b_mem0", 32'(env_mem[8'h30]), 32'h0011);
    chk("b2b_mem1", 32'(env_mem[8'h31]), 32'h0022);
    tick();
    bus.cpu_read = 1; bus.cpu_addr = 16'h0004;
    bus.dbg_req = 1; bus.dbg_write = 0; bus.dbg_addr = 16'h0010;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("mid_state_wait", 32'(dut.r_state), 32'(ST_WAIT));
    tick();
    rst_n = 0;
    bus.dbg_req = 0;
    @(negedge clk);
    chk("mid_rst_read", 32'(bus.mem_read), 0);
    chk("mid_rst_stall", 32'(bus.cpu_stall), 0);
    tick();
    rst_n = 1;
    bus.cpu_read = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_ack", 32'(bus.dbg_ack), 0);
      chk("mid_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
